// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//
// Two-channel contact conditioner for slide switches and push buttons.
// Each raw input passes through a 2-FF synchronizer. A stability counter
// then lets the output follow the synchronized level only after that level
// has differed from the output for STABLE_CNT consecutive clocks. The
// cleaned levels A and B drive the downstream and_gate inputs directly.
// Channel A and channel B are independent and share only the clock and reset.
//
// Parameters:
//   STABLE_CNT  clocks the synchronized input must differ from the output
//               before the output follows it (legal range 1 .. 2^CNT_W-1)
//   CNT_W       width of each channel's stability counter
//
// Ports:
//   CLK      in   system clock
//   RST_N    in   synchronous reset, active-low
//   SW_A_IN  in   raw asynchronous contact, channel A
//   SW_B_IN  in   raw asynchronous contact, channel B
//   A        out  debounced level, channel A (registered)
//   B        out  debounced level, channel B (registered)
//   A_EDGE   out  one-cycle pulse on any change of A  (DEBOUNCE_EDGE_EN only)
//   B_EDGE   out  one-cycle pulse on any change of B  (DEBOUNCE_EDGE_EN only)
//
// Build option:
//   DEBOUNCE_EDGE_EN  when defined, adds the A_EDGE/B_EDGE pulse outputs.
// -----------------------------------------------------------------------------
module switch_debounce #(
  parameter int STABLE_CNT = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SW_A_IN,
  input  logic SW_B_IN,
  output logic A,
  output logic B
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic A_EDGE,
  output logic B_EDGE
`endif
);

  // Per-channel state is implied by comparing the synchronized input with
  // the current output; there is no separate state register.
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_COUNT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  // Reject configurations where the counter could never reach CNT_LAST.
  if (STABLE_CNT < 1 || STABLE_CNT > (2 ** CNT_W) - 1) begin : g_bad_param
    $error("switch_debounce: STABLE_CNT=%0d out of range 1..%0d for CNT_W=%0d",
           STABLE_CNT, (2 ** CNT_W) - 1, CNT_W);
  end

  // Index 0 is channel A, index 1 is channel B.
  logic [1:0]       raw;
  logic [1:0]       sync0_q;
  logic [1:0]       sync1_q;
  logic [1:0]       out_q;
  logic [1:0]       out_d;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign raw = {SW_B_IN, SW_A_IN};

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    out_d    = out_q;
    state    = '0;
    cnt_d[0] = '0;
    cnt_d[1] = '0;
    for (int ch = 0; ch < 2; ch++) begin
      state[ch] = (sync1_q[ch] != out_q[ch]) ? ST_COUNT : ST_IDLE;
      case (state[ch])
        ST_IDLE: begin
          // Input agrees with output: any partial count is discarded.
          cnt_d[ch] = '0;
        end
        ST_COUNT: begin
          if (cnt_q[ch] == CNT_LAST) begin
            out_d[ch] = sync1_q[ch];
            cnt_d[ch] = '0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + 1'b1;
          end
        end
        default: cnt_d[ch] = '0;
      endcase
    end
  end

  // NOTE: reset is sampled on the clock edge only; RST_N is not in the
  // sensitivity list, so a reset pulse shorter than a clock period is ignored.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync0_q  <= '0;
      sync1_q  <= '0;
      out_q    <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync1_q capture the old sync0_q,
      // giving two real flop stages instead of one collapsed stage.
      sync0_q  <= raw;
      sync1_q  <= sync0_q;
      out_q    <= out_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign A = out_q[0];
  assign B = out_q[1];

`ifdef DEBOUNCE_EDGE_EN
  logic [1:0] edge_q;
  logic [1:0] edge_d;

  // Pulse on the same edge the output changes, in either direction.
  assign edge_d = out_d ^ out_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      edge_q <= '0;
    end else begin
      edge_q <= edge_d;
    end
  end

  assign A_EDGE = edge_q[0];
  assign B_EDGE = edge_q[1];
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
//
// Self-checking bench for switch_debounce with STABLE_CNT=4, CNT_W=3.
// Each step drives the inputs at the falling edge and pushes the expected
// outputs after the next rising edge onto a scoreboard queue. The expected
// values come from a sample-history model: an output flips when the last
// STABLE_CNT synchronized samples all disagree with it. The entry is popped
// and compared just after that rising edge. Directed latency checks count
// edges from reset release to the output rising.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

  localparam int SC = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic sw_a;
  logic sw_b;
  logic a;
  logic b;
`ifdef DEBOUNCE_EDGE_EN
  logic a_edge;
  logic b_edge;
`endif

  always #5 clk = ~clk;

  switch_debounce #(
    .STABLE_CNT(SC),
    .CNT_W     (CW)
  ) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .SW_A_IN(sw_a),
    .SW_B_IN(sw_b),
    .A      (a),
    .B      (b)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .A_EDGE (a_edge),
    .B_EDGE (b_edge)
`endif
  );

  typedef struct packed {
    logic a;
    logic b;
    logic ea;
    logic eb;
  } exp_t;

  exp_t exp_q[$];

  int    n_checks = 0;
  int    n_errors = 0;
  string phase    = "init";

  // Reference model state, index 0 = A, 1 = B.
  logic [1:0]    m_s0   = '0;
  logic [1:0]    m_s1   = '0;
  logic [1:0]    m_out  = '0;
  logic [1:0]    m_edg  = '0;
  logic [SC-1:0] m_hist [2] = '{default: '0};

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance the model by one rising edge with the given inputs.
  task automatic model_edge(input logic ra, input logic rb, input logic rn);
    logic [1:0] r;
    r = {rb, ra};
    for (int c = 0; c < 2; c++) begin
      if (!rn) begin
        m_s0[c]   = 1'b0;
        m_s1[c]   = 1'b0;
        m_out[c]  = 1'b0;
        m_edg[c]  = 1'b0;
        m_hist[c] = '0;
      end else begin
        m_hist[c] = {m_hist[c][SC-2:0], m_s1[c]};
        m_s1[c]   = m_s0[c];
        m_s0[c]   = r[c];
        m_edg[c]  = 1'b0;
        if (m_hist[c] == {SC{~m_out[c]}}) begin
          m_out[c] = ~m_out[c];
          m_edg[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic ra, input logic rb, input logic rn);
    exp_t e;
    exp_t got;
    @(negedge clk);
    sw_a  = ra;
    sw_b  = rb;
    rst_n = rn;
    model_edge(ra, rb, rn);
    e.a  = m_out[0];
    e.b  = m_out[1];
    e.ea = m_edg[0];
    e.eb = m_edg[1];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({phase, ".A"}, 32'(a), 32'(got.a));
    check({phase, ".B"}, 32'(b), 32'(got.b));
`ifdef DEBOUNCE_EDGE_EN
    check({phase, ".A_EDGE"}, 32'(a_edge), 32'(got.ea));
    check({phase, ".B_EDGE"}, 32'(b_edge), 32'(got.eb));
`endif
  endtask

  task automatic hold(input logic ra, input logic rb, input int n);
    for (int i = 0; i < n; i++) step(ra, rb, 1'b1);
  endtask

  // Release reset with SW_A_IN=1 and count edges after the first released
  // edge until A is seen high; bounded at 20 edges.
  task automatic rise_latency(input string tag, input logic rb);
    int steps;
    steps = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, rb, 1'b1);
      steps++;
      if (a === 1'b1) break;
    end
    check(tag, 32'(steps - 1), 32'd5);
  endtask

  initial begin
    rst_n = 1'b0;
    sw_a  = 1'b1;
    sw_b  = 1'b1;

    // Reset held for three edges with both contacts high.
    phase = "reset";
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    phase = "release";
    rise_latency("rst_release_latency", 1'b1);
    check("release.B_high", 32'(b), 32'd1);
    hold(1'b1, 1'b1, 3);

    // Bring A low, then a clean 0->1 on A with B held.
    phase = "a_fall";
    hold(1'b0, 1'b1, 8);
    phase = "a_rise";
    hold(1'b1, 1'b1, 8);
    phase = "a_fall2";
    hold(1'b0, 1'b1, 8);

    // Short pulses on A never complete and never accumulate.
    phase = "glitch";
    hold(1'b1, 1'b1, 3);
    hold(1'b0, 1'b1, 3);
    hold(1'b1, 1'b1, 3);
    hold(1'b0, 1'b1, 6);
    check("glitch.A_low", 32'(a), 32'd0);

    // B bounce: low first, then 1,0,1,0,1 and hold 1.
    phase = "b_low";
    hold(1'b0, 1'b0, 8);
    phase = "bounce";
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    hold(1'b0, 1'b1, 8);
    check("bounce.B_high", 32'(b), 32'd1);

    // Both channels fall on the same cycle.
    phase = "both_high";
    hold(1'b1, 1'b1, 8);
    phase = "both_fall";
    hold(1'b0, 1'b0, 8);

    // Reset while A is mid-count (cnt=2 after the fourth edge).
    phase = "mid_count";
    hold(1'b1, 1'b0, 4);
    phase = "mid_reset";
    step(1'b1, 1'b0, 1'b0);
    phase = "mid_release";
    rise_latency("rst_mid_latency", 1'b0);
    hold(1'b1, 1'b0, 3);

    // Random contact activity with variable hold lengths.
    phase = "random";
    for (int i = 0; i < 60; i++) begin
      logic ra;
      logic rb;
      int   len;
      ra  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      hold(ra, rb, len);
    end
    hold(1'b0, 1'b0, 8);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
